// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_ctrl_pkg : shared types and constants for the FFT iteration controller
// Revision     : 1.0
// -----------------------------------------------------------------------------
package fft_ctrl_pkg;

  localparam int MAX_LOG2_DEF = 10;
  localparam int LAY_WL_DEF   = $clog2(MAX_LOG2_DEF + 1);
  localparam int BUTT_WL_DEF  = MAX_LOG2_DEF - 1;
  localparam int WAIT_WL      = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_STROB    = 3'd3,
    ST_BUT_WAIT = 3'd4,
    ST_WRITE    = 3'd5,
    ST_GAP      = 3'd6
  } state_t;

  function automatic int fft_period(input int rd_lat, input int but_lat, input int wr_gap);
    return 3 + rd_lat + but_lat + wr_gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_fft_iter_gen_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// control_unit_fft_iter_gen_if : command and strobe bundle of the FFT controller
// Revision                     : 1.0
// -----------------------------------------------------------------------------
interface control_unit_fft_iter_gen_if
  import fft_ctrl_pkg::*;
#(
  parameter int LayWL  = LAY_WL_DEF,
  parameter int ButtWL = BUTT_WL_DEF
);

  logic              EN;
  logic              START;
  logic              ABORT;
  logic [LayWL-1:0]  N_LOG2;
  logic              BUSY;
  logic              BUT_STROB;
  logic              ADDR_EN;
  logic              ADDR_RST;
  logic              RAM_EN_R;
  logic              RAM_EN_WR;
  logic              Wr;
  logic              LAY_EN;
  logic              LAST_LAY;
  logic [LayWL-1:0]  LAY_IDX;
  logic [ButtWL-1:0] BUTT_IDX;
  logic              DONE;
  logic              ERR;

  // master is the controller, slave is the host/datapath side
  modport master (
    input  EN, START, ABORT, N_LOG2,
    output BUSY, BUT_STROB, ADDR_EN, ADDR_RST, RAM_EN_R, RAM_EN_WR, Wr,
           LAY_EN, LAST_LAY, LAY_IDX, BUTT_IDX, DONE, ERR
  );

  modport slave (
    output EN, START, ABORT, N_LOG2,
    input  BUSY, BUT_STROB, ADDR_EN, ADDR_RST, RAM_EN_R, RAM_EN_WR, Wr,
           LAY_EN, LAST_LAY, LAY_IDX, BUTT_IDX, DONE, ERR
  );

endinterface
`default_nettype wire

// File: rtl/fft_ctrl_wait_cnt.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_ctrl_wait_cnt : loadable down-counter with zero flag, frozen by hold
// Revision          : 1.0
// -----------------------------------------------------------------------------
module fft_ctrl_wait_cnt
  import fft_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               load,
  input  logic [WAIT_WL-1:0] load_val,
  output logic               zero
);

  logic [WAIT_WL-1:0] r_cnt;

  // saturates at zero so a wait state that outlives its count stays ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        r_cnt <= load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - WAIT_WL'(1);
      end
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/control_unit_fft_iter_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// control_unit_fft_iter_gen : read/strobe/write sequencer for in-place radix-2 FFT
// Revision                  : 1.0
// -----------------------------------------------------------------------------
module control_unit_fft_iter_gen
  import fft_ctrl_pkg::*;
#(
  parameter int MAX_LOG2 = MAX_LOG2_DEF,
  parameter int LayWL    = LAY_WL_DEF,
  parameter int ButtWL   = BUTT_WL_DEF,
  parameter int RD_LAT   = 1,
  parameter int BUT_LAT  = 0,
  parameter int WR_GAP   = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  control_unit_fft_iter_gen_if.master bus
);

  state_t             r_state;
  state_t             w_next;
  logic [LayWL-1:0]   r_n;
  logic [LayWL-1:0]   r_lay;
  logic [ButtWL-1:0]  r_butt;
  logic               r_done;
  logic               r_err;

  logic               w_wait_load;
  logic [WAIT_WL-1:0] w_wait_val;
  logic               w_wait_zero;

  logic               w_size_ok;
  logic [ButtWL:0]    w_span;
  logic [ButtWL:0]    w_butt_max;
  logic               w_butt_last;
  logic               w_lay_last;
  logic               w_final;

  logic               w_busy;
  logic               w_strob;
  logic               w_read;
  logic               w_write;

  assign w_size_ok   = (bus.N_LOG2 >= LayWL'(2)) && (bus.N_LOG2 <= LayWL'(MAX_LOG2));

  // one extra bit so 2^(n-1) is representable before the -1
  assign w_span      = (ButtWL+1)'(1) << (r_n - LayWL'(1));
  assign w_butt_max  = w_span - (ButtWL+1)'(1);
  assign w_butt_last = ({1'b0, r_butt} == w_butt_max);
  assign w_lay_last  = (r_lay == (r_n - LayWL'(1)));
  assign w_final     = w_butt_last && w_lay_last;

  fft_ctrl_wait_cnt u_wait_cnt (
    .clk      (CLK),
    .rst_n    (RST),
    .hold     (~bus.EN),
    .load     (w_wait_load),
    .load_val (w_wait_val),
    .zero     (w_wait_zero)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_load = 1'b0;
    w_wait_val  = '0;
    w_busy      = (r_state != ST_IDLE);
    w_strob     = (r_state == ST_STROB);
    w_read      = (r_state == ST_READ);
    w_write     = (r_state == ST_WRITE);

    if (bus.EN) begin
      if ((r_state != ST_IDLE) && bus.ABORT) begin
        w_next = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.START && w_size_ok) begin
              w_next = ST_READ;
            end
          end
          ST_READ: begin
            if (RD_LAT > 0) begin
              w_next      = ST_RD_WAIT;
              w_wait_load = 1'b1;
              w_wait_val  = WAIT_WL'(RD_LAT - 1);
            end else begin
              w_next = ST_STROB;
            end
          end
          ST_RD_WAIT: begin
            if (w_wait_zero) begin
              w_next = ST_STROB;
            end
          end
          ST_STROB: begin
            if (BUT_LAT > 0) begin
              w_next      = ST_BUT_WAIT;
              w_wait_load = 1'b1;
              w_wait_val  = WAIT_WL'(BUT_LAT - 1);
            end else begin
              w_next = ST_WRITE;
            end
          end
          ST_BUT_WAIT: begin
            if (w_wait_zero) begin
              w_next = ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (w_final) begin
              w_next = ST_IDLE;
            end else if (WR_GAP > 0) begin
              w_next      = ST_GAP;
              w_wait_load = 1'b1;
              w_wait_val  = WAIT_WL'(WR_GAP - 1);
            end else begin
              w_next = ST_READ;
            end
          end
          ST_GAP: begin
            if (w_wait_zero) begin
              w_next = ST_READ;
            end
          end
          default: begin
            w_next = ST_IDLE;
          end
        endcase
      end
    end
  end

  // indices are cleared whenever the controller falls back to IDLE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_n    <= '0;
      r_lay  <= '0;
      r_butt <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (bus.EN) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.START) begin
          if (w_size_ok) begin
            r_n    <= bus.N_LOG2;
            r_lay  <= '0;
            r_butt <= '0;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else if (bus.ABORT) begin
        r_lay  <= '0;
        r_butt <= '0;
      end else if (r_state == ST_WRITE) begin
        if (w_final) begin
          r_done <= 1'b1;
          r_lay  <= '0;
          r_butt <= '0;
        end else if (w_butt_last) begin
          r_butt <= '0;
          r_lay  <= r_lay + LayWL'(1);
        end else begin
          r_butt <= r_butt + ButtWL'(1);
        end
      end
    end
  end

  assign bus.BUSY      = w_busy;
  assign bus.BUT_STROB = w_strob;
  assign bus.ADDR_EN   = w_write;
  assign bus.ADDR_RST  = ~w_busy;
  assign bus.RAM_EN_R  = w_read;
  assign bus.RAM_EN_WR = w_write;
  assign bus.Wr        = w_write;
  assign bus.LAY_EN    = w_write && w_butt_last && !w_lay_last;
  assign bus.LAST_LAY  = w_busy && w_lay_last;
  assign bus.LAY_IDX   = r_lay;
  assign bus.BUTT_IDX  = r_butt;
  assign bus.DONE      = r_done;
  assign bus.ERR       = r_err;

endmodule
`default_nettype wire

// File: doc/control_unit_fft_iter_gen.md
Name: control_unit_fft_iter_gen

Overview:
Parametrised controller for the in-place iterative radix-2 FFT core. It sequences the per-butterfly read, butterfly strobe and write steps for a runtime-selectable transform size of 2^N_LOG2 points. RAM read latency, butterfly pipeline latency and the write gap are all set by parameters. It drives the address generator, the RAM enables and the butterfly unit. It also adds abort, a done pulse, a size-error flag and exported layer/butterfly indices.

Parameters:
MAX_LOG2, 10, largest supported log2(points); legal runtime range is 2..MAX_LOG2.
LayWL, 4, width of the layer index and of N_LOG2; must be at least clog2(MAX_LOG2+1).
ButtWL, 9, width of the butterfly index; equals MAX_LOG2-1.
RD_LAT, 1, RAM read latency in cycles (0..7); sets the length of RD_WAIT.
BUT_LAT, 0, butterfly pipeline latency in cycles (0..7); sets the length of BUT_WAIT.
WR_GAP, 1, idle cycles after each write (0..7); sets the length of GAP.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  asynchronous, active-low reset.
EN  in  1  clock enable; when low, state, counters and flags hold.
START  in  1  start request; sampled only in IDLE.
ABORT  in  1  abandon the current transform.
N_LOG2  in  LayWL  transform size as log2(points); latched when START is accepted.
BUSY  out  1  high in every state except IDLE.
BUT_STROB  out  1  high in STROB.
ADDR_EN  out  1  high in WRITE; advances the address generator.
ADDR_RST  out  1  high in IDLE.
RAM_EN_R  out  1  high in READ.
RAM_EN_WR  out  1  high in WRITE.
Wr  out  1  high in WRITE.
LAY_EN  out  1  high in WRITE of the last butterfly of any layer except the final layer.
LAST_LAY  out  1  high for the whole final layer.
LAY_IDX  out  LayWL  current layer, 0..n-1.
BUTT_IDX  out  ButtWL  current butterfly within the layer, 0..2^(n-1)-1.
DONE  out  1  one-cycle pulse after the final write.
ERR  out  1  one-cycle pulse when START is rejected because of an illegal size.

Behaviour:
- Reset (RST=0, asynchronous): state goes to IDLE and all counters clear. ADDR_RST=1; every other output is 0.
- States: IDLE, READ, RD_WAIT, STROB, BUT_WAIT, WRITE, GAP. Strobe outputs are Moore decodes of the state.
- IDLE with START=1:
  - If 2 <= N_LOG2 <= MAX_LOG2: latch n=N_LOG2, clear the counters, go to READ.
  - Otherwise: pulse ERR for one cycle and stay in IDLE.
- READ goes to RD_WAIT, which lasts RD_LAT cycles; RD_LAT=0 skips it and goes straight to STROB.
- STROB goes to BUT_WAIT, which lasts BUT_LAT cycles and is skipped when BUT_LAT=0, then to WRITE.
- WRITE:
  - If this is the last butterfly of the last layer: go to IDLE and assert DONE in the following cycle.
  - Otherwise: go to GAP, which lasts WR_GAP cycles and is skipped when WR_GAP=0, then back to READ.
- Per-butterfly period P = 3 + RD_LAT + BUT_LAT + WR_GAP (5 with the defaults).
- Counters:
  - BUTT_IDX and LAY_IDX stay stable for the whole butterfly and update at the end of WRITE.
  - BUTT_IDX wraps to 0 at 2^(n-1)-1, and LAY_IDX increments on that wrap.
  - LAST_LAY is high while LAY_IDX = n-1.
- BUSY duration: BUSY is high from the cycle after START is accepted for n*2^(n-1)*P - WR_GAP cycles.
- START while busy is ignored.
- ABORT:
  - In any non-IDLE state, ABORT=1 with EN=1 moves to IDLE on the next edge; no WRITE is issued and DONE is not asserted.
  - ABORT has priority over every other transition.
  - ABORT in IDLE has no effect.
- EN=0 freezes the state, the wait counters and the indices. The outputs keep decoding the held state, so a strobe can stay high for several cycles and the downstream units must also be gated by EN.
- N_LOG2 changes after acceptance have no effect until the next START.
- Reset in the middle of a transform: immediate return to IDLE, no DONE.
- A single wait counter, reloaded on entry to each wait state, serves RD_WAIT, BUT_WAIT and GAP.

Decomposition:
- Package fft_ctrl_pkg holds:
  - the state encoding localparams;
  - the MAX_LOG2-derived widths;
  - the function that computes the per-butterfly period.
- Sub-module fft_ctrl_wait_cnt is a 3-bit loadable down-counter with a zero flag and a hold input driven by EN. It is instantiated once.

Test Plan:
1. Defaults, N_LOG2=5, START for one cycle. Expect BUSY high for 5*16*5-1=399 cycles and BUT_STROB to pulse 80 times at a 5-cycle spacing. Expect LAY_EN to pulse 4 times and LAST_LAY to be high for the last 16 butterflies. Expect one DONE pulse in the cycle after the final Wr.
2. RD_LAT=0, BUT_LAT=2, WR_GAP=0, N_LOG2=2. Expect P=5 and 4 butterflies with no WRITE followed by READ gap. Expect BUSY high for 20 cycles and BUTT_IDX/LAY_IDX to follow 0/0, 1/0, 0/1, 1/1.
3. START with N_LOG2=1, and again with N_LOG2=11 (MAX_LOG2=10). Expect an ERR pulse each time, BUSY to stay 0 and no strobes.
4. ABORT asserted during BUT_WAIT of butterfly 7 of a 32-point run. Expect IDLE on the next edge, no Wr, no DONE, and ADDR_RST=1. A following START runs a full transform correctly.
5. EN held low for 3 cycles during STROB. Expect BUT_STROB to stay high for 4 cycles with only one increment of BUTT_IDX, and the total busy length to extend by exactly 3 cycles.
6. RST pulled low in the middle of a layer, asynchronously between edges. Expect the outputs to reach their reset values without waiting for a clock edge, no DONE, and a clean restart on the next START.
